// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register carrying a data bundle and a
// control bundle behind a valid/ready handshake. It has an optional two-entry
// skid buffer (SKID=1), which keeps out_ready off the in_ready path.
// Control bits read as zero on bubbles, so downstream write enables stay quiet.
// The stage also counts stalled cycles in a saturating counter.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic accept;
  logic emit;
  logic main_v_d;
  logic skid_v_d;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign accept = in_valid && in_ready;
  assign emit   = main_v && out_ready;

  // With a skid entry, ready comes straight from a flop.
  // Without one, ready must look at out_ready in the same cycle.
  generate
    if (SKID != 0) begin : g_ready
      assign in_ready = !skid_v;
    end else begin : g_ready
      assign in_ready = !main_v || out_ready;
    end
  endgenerate

  // Next occupancy and load selects. Flush overrides all of them.
  // The skid entry can only fill while main holds a beat that is not leaving,
  // and with SKID=0 that case never accepts, so one decode serves both modes.
  always_comb begin
    main_v_d     = main_v;
    skid_v_d     = skid_v;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!main_v) begin
      if (accept) begin
        ld_main_in = 1'b1;
        main_v_d   = 1'b1;
      end
    end else if (emit) begin
      if (skid_v) begin
        ld_main_skid = 1'b1;
        skid_v_d     = 1'b0;
      end else if (accept) begin
        ld_main_in = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      ld_skid  = 1'b1;
      skid_v_d = 1'b1;
    end
    if (flush) begin
      main_v_d     = 1'b0;
      skid_v_d     = 1'b0;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Main entry: the valid bit follows the decode. The payload loads only on a
  // transfer into the entry and otherwise holds, including across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v    <= 1'b0;
      main_data <= '0;
      main_ctrl <= '0;
    end else begin
      main_v <= main_v_d;
      if (ld_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Skid entry: catches the beat that was accepted while main was stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_v    <= 1'b0;
          skid_data <= '0;
          skid_ctrl <= '0;
        end else begin
          skid_v <= skid_v_d;
          if (ld_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end
        end
      end
    end else begin : g_no_skid
      assign skid_v    = 1'b0;
      assign skid_data = '0;
      assign skid_ctrl = '0;
    end
  endgenerate

  // Stall counter: counts cycles where a beat is held back, saturates at all
  // ones, and is cleared only by stall_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_v ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. One instance has the skid buffer and a 4-bit
// counter, the other has a single entry and a 16-bit counter. Both get the
// same stimulus. Each one is checked every cycle against a queue model of
// capacity 2 or 1.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ctrl;
  logic        flush;
  logic        out_ready;
  logic        stall_clr;

  logic        in_ready1, out_valid1;
  logic [15:0] out_data1;
  logic [3:0]  out_ctrl1;
  logic [3:0]  stall_cnt1;
  logic        in_ready0, out_valid0;
  logic [15:0] out_data0;
  logic [3:0]  out_ctrl0;
  logic [15:0] stall_cnt0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .stall_cnt(stall_cnt1), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .stall_cnt(stall_cnt0), .stall_clr(stall_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each stage is a FIFO of {ctrl, data} beats.
  logic [19:0] q1[$];
  logic [19:0] q0[$];
  int          cnt1 = 0;
  int          cnt0 = 0;
  logic [15:0] seen1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] d, input logic [3:0] c,
                       input logic ordy, input logic fl, input logic clr);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    #1;
  endtask

  task automatic check_all();
    logic v1, v0;
    v1 = (q1.size() > 0);
    v0 = (q0.size() > 0);
    chk("skid_out_valid", 32'(out_valid1), 32'(v1));
    chk("skid_in_ready",  32'(in_ready1),  32'(q1.size() < 2));
    chk("skid_out_ctrl",  32'(out_ctrl1),  v1 ? 32'(q1[0][19:16]) : 32'd0);
    if (v1) chk("skid_out_data", 32'(out_data1), 32'(q1[0][15:0]));
    chk("skid_stall_cnt", 32'(stall_cnt1), 32'(cnt1));
    chk("nosk_out_valid", 32'(out_valid0), 32'(v0));
    chk("nosk_in_ready",  32'(in_ready0),  32'((q0.size() == 0) || out_ready));
    chk("nosk_out_ctrl",  32'(out_ctrl0),  v0 ? 32'(q0[0][19:16]) : 32'd0);
    if (v0) chk("nosk_out_data", 32'(out_data0), 32'(q0[0][15:0]));
    chk("nosk_stall_cnt", 32'(stall_cnt0), 32'(cnt0));
  endtask

  // Advance one edge and move the model by the handshake rules.
  task automatic tick();
    logic v1, r1, v0, r0;
    v1 = (q1.size() > 0);
    r1 = (q1.size() < 2);
    v0 = (q0.size() > 0);
    r0 = (q0.size() == 0) || out_ready;
    if (out_valid1 && out_ready) seen1.push_back(out_data1);
    @(posedge clk);
    if (stall_clr) cnt1 = 0;
    else if (v1 && !out_ready && cnt1 < 15) cnt1++;
    if (stall_clr) cnt0 = 0;
    else if (v0 && !out_ready && cnt0 < 65535) cnt0++;
    if (v1 && out_ready) void'(q1.pop_front());
    if (in_valid && r1) q1.push_back({in_ctrl, in_data});
    if (flush) q1.delete();
    if (v0 && out_ready) void'(q0.pop_front());
    if (in_valid && r0) q0.push_back({in_ctrl, in_data});
    if (flush) q0.delete();
    #1;
  endtask

  task automatic cyc(input logic iv, input logic [15:0] d, input logic [3:0] c,
                     input logic ordy, input logic fl, input logic clr);
    drive(iv, d, c, ordy, fl, clr);
    check_all();
    tick();
  endtask

  initial begin
    logic [15:0] bp_exp [3];
    bp_exp = '{16'h00A0, 16'h00A1, 16'h00A2};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_data",  32'(out_data1),  32'd0);
    chk("rst_out_ctrl",  32'(out_ctrl1),  32'd0);
    chk("rst_in_ready",  32'(in_ready1),  32'd1);
    chk("rst_stall",     32'(stall_cnt1), 32'd0);
    chk("rst_in_ready0", 32'(in_ready0),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming through both stages with out_ready held high.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 4'b1010, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Bubble gating: the stage goes idle and ctrl reads zero, but data holds.
    cyc(1'b1, 16'h00BB, 4'hF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("bubble_valid", 32'(out_valid1), 32'd0);
    chk("bubble_ctrl",  32'(out_ctrl1),  32'd0);
    chk("bubble_data",  32'(out_data1),  32'h00BB);
    chk("bubble_ctrl0", 32'(out_ctrl0),  32'd0);

    // Back-pressure into the skid entry, then release.
    seen1.delete();
    cyc(1'b1, 16'h00A0, 4'h3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A1, 4'h3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 4'h3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 4'h3, 1'b0, 1'b0, 1'b0);
    chk("bp_stall_cnt", 32'(stall_cnt1), 32'd3);
    chk("bp_in_ready",  32'(in_ready1),  32'd0);
    cyc(1'b1, 16'h00A2, 4'h3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 4'h3, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_order_len", 32'(seen1.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < seen1.size()) chk("bp_order", 32'(seen1[i]), 32'(bp_exp[i]));

    // Flush with both entries full and a new beat offered.
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'h00C0, 4'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00C1, 4'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00C2, 4'h5, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 32'(out_valid1), 32'd0);
    chk("flush_ctrl",  32'(out_ctrl1),  32'd0);
    // Flush together with an emit and an accepted beat.
    cyc(1'b1, 16'h00D0, 4'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00D1, 4'h5, 1'b1, 1'b1, 1'b0);
    chk("flush_emit_valid", 32'(out_valid1), 32'd0);
    cyc(1'b1, 16'h0055, 4'h6, 1'b1, 1'b0, 1'b0);
    chk("post_flush_data", 32'(out_data1), 32'h0055);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Counter saturation and clear-over-increment.
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'h0077, 4'h1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt4",  32'(stall_cnt1), 32'd15);
    chk("sat_cnt16", 32'(stall_cnt0), 32'd20);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 32'(stall_cnt1), 32'd0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("clr_then_inc", 32'(stall_cnt1), 32'd1);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // SKID=0: in_ready follows out_ready combinationally.
    cyc(1'b1, 16'h0011, 4'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0033, 4'h4, 1'b0, 1'b0, 1'b0);
    chk("nosk_rdy_low", 32'(in_ready0), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("nosk_rdy_high", 32'(in_ready0), 32'd1);
    check_all();
    tick();
    chk("nosk_replace", 32'(out_data0), 32'h0033);
    chk("nosk_replace_v", 32'(out_valid0), 32'd1);

    // Asynchronous reset in the middle of a stalled stream.
    cyc(1'b1, 16'h0044, 4'h7, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0045, 4'h7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid1", 32'(out_valid1), 32'd0);
    chk("arst_stall1", 32'(stall_cnt1), 32'd0);
    chk("arst_valid0", 32'(out_valid0), 32'd0);
    chk("arst_stall0", 32'(stall_cnt0), 32'd0);
    chk("arst_ctrl1",  32'(out_ctrl1),  32'd0);
    in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 19) == 0));
    cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
